instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_ADDRESS, default 32'h0000_0100, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req_valid  output  1  fetch request pending.
REQ-006 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port mem_req_addr  output  [0:31]  word-aligned fetch address, bits 30:31 always 0.
REQ-008 SHALL have port mem_resp_valid  input  1  read data valid; responses return in request order and are always accepted.
REQ-009 SHALL have port mem_resp_data  input  [0:31]  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/exception redirect, single-cycle pulse.
REQ-011 SHALL have port redirect_target  input  [0:31]  new fetch address; bits 30:31 ignored.
REQ-012 SHALL have port instruction_valid  output  1  to instruction_decode.
REQ-013 SHALL have port instruction_ready  input  1  from instruction_decode.
REQ-014 SHALL have port instruction  output  [0:31]  fetched word, big-endian bit order.
REQ-015 SHALL have port instruction_address  output  [0:31]  address of the presented instruction.

Function
REQ-016 SHALL keep a PC register holding the next address to request; PC += 4 on each request load, wrapping 32'hFFFF_FFFC -> 0.
REQ-017 SHALL hold mem_req_valid and mem_req_addr stable from assertion until mem_req_valid & mem_req_ready.
REQ-018 SHALL keep a reservation count = requests loaded + buffered entries; load a new request only when count < FIFO_DEPTH, so the buffer never overflows.
REQ-019 SHALL issue back-to-back: a new request may load in the same cycle the previous one is accepted, giving 1 request/cycle sustained.
REQ-020 SHALL write each non-stale response into the buffer with its address; earliest visible on instruction_valid the cycle after mem_resp_valid.
REQ-021 SHALL present buffer head on instruction/instruction_address; pop on instruction_valid & instruction_ready; reservation released on pop.
REQ-022 SHALL, on redirect_valid: flush the buffer, set PC to {redirect_target[0:29],2'b00}, set stale counter = accepted-but-unreturned requests + pending unaccepted request, release those reservations as stale responses arrive.
REQ-023 SHALL force instruction_valid low in the redirect cycle; no pop occurs.
REQ-024 SHALL discard a response arriving in the redirect cycle or while stale counter > 0 (decrementing it).
REQ-025 SHALL leave a pending unaccepted request in place on redirect (counted stale); first target-path request loads after it is accepted.
REQ-026 SHALL handle simultaneous push and pop on a full or empty buffer without loss or duplication.

Reset
REQ-027 SHALL in reset cycle(s) set mem_req_valid=0, mem_req_addr=0, instruction_valid=0, PC=RESET_ADDRESS, buffer empty, reservation and stale counters 0.
REQ-028 SHALL discard responses and ignore redirect_valid while rst is high; first request (RESET_ADDRESS) is presented the cycle after rst deasserts.

Structure
REQ-029 SHALL place fetch_entry_t {address[0:31], instruction[0:31]} and DEFAULT_RESET_ADDRESS in ppc_types.
REQ-030 SHALL implement the buffer as sub-module fetch_fifo (parameter DEPTH, synchronous flush input).

Verification
REQ-031 SHALL test reset release with memory ready=1, 1-cycle latency, decode ready=1: addresses 0x100,0x104,0x108 stream at 1 instr/cycle.
REQ-032 SHALL test decode ready=0 for 10 cycles: exactly 4 (FIFO_DEPTH) requests issued, then mem_req_valid stays 0 until a pop.
REQ-033 SHALL test redirect to 0x2003 with 3 requests in flight: those 3 responses dropped, next instruction_address = 0x2000.
REQ-034 SHALL test mem_req_ready=0 while redirect pulses: pending address unchanged until accepted, then next request 0x2000.
REQ-035 SHALL test PC 0xFFFF_FFFC fetch: next request address 0x0000_0000.
REQ-036 SHALL test rst asserted with buffer full and responses outstanding: all outputs at reset values next cycle, fetch restarts at 0x100.

Source files
------------

// File: rtl/ppc_types.sv
// Shared types and constants for the fetch front end.
package ppc_types;

    localparam logic [0:31] DEFAULT_RESET_ADDRESS = 32'h0000_0100;
    localparam logic [0:31] FETCH_STRIDE          = 32'h0000_0004;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [0:31] address;
        logic [0:31] instruction;
    } fetch_entry_t;

    // Clear the two byte-offset bits so the address is word aligned.
    function automatic logic [0:31] word_align(input logic [0:31] addr);
        return {addr[0:29], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO of fetch entries with a synchronous flush.
module fetch_fifo
    import ppc_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned  AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]  CNT_ONE    = (AW + 1)'(1'b1);
    localparam logic [AW:0]  CNT_ZERO   = {(AW + 1){1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty = (count_q == CNT_ZERO);
    assign head  = mem_q[rd_ptr_q];

    // Pointer/count/storage update; a push into a full buffer is allowed only alongside a pop.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        full_s    = (count_q == FULL_COUNT);
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full_s | do_pop_s);
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (do_push_s ? CNT_ONE : CNT_ZERO) - (do_pop_s ? CNT_ONE : CNT_ZERO);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {$bits(fetch_entry_t){1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues word fetches from a PC, buffers responses in order,
// and presents them to decode. Redirects flush the buffer and drop in-flight data.
module instruction_fetch
    import ppc_types::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [0:31] RESET_ADDRESS = DEFAULT_RESET_ADDRESS
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [0:31] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [0:31] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [0:31] redirect_target,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [0:31] instruction,
    output logic [0:31] instruction_address
);

    localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic [0:31]   pc_q, pc_d;
    logic          req_valid_q, req_valid_d;
    logic [0:31]   req_addr_q, req_addr_d;
    // Address of the next non-stale response; responses are in order and
    // the live ones always form a sequential run from the last redirect.
    logic [0:31]   resp_addr_q, resp_addr_d;
    logic [CW-1:0] resv_q, resv_d;
    logic [CW-1:0] stale_q, stale_d;
    logic [CW-1:0] outst_q, outst_d;

    logic          accept_s;
    logic          load_s;
    logic          pop_s;
    logic          keep_s;
    logic          drop_s;
    logic          flush_s;
    logic          fifo_empty_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;

    assign accept_s     = req_valid_q & mem_req_ready;
    assign load_s       = ~redirect_valid & (~req_valid_q | accept_s) & (resv_q < DEPTH_C);
    assign pop_s        = instruction_valid & instruction_ready;
    assign keep_s       = mem_resp_valid & ~redirect_valid & (stale_q == ZERO_C);
    assign drop_s       = mem_resp_valid & ~redirect_valid & (stale_q != ZERO_C);
    assign flush_s      = redirect_valid & ~rst;
    assign push_entry_s = '{address: resp_addr_q, instruction: mem_resp_data};

    assign mem_req_valid       = req_valid_q;
    assign mem_req_addr        = req_addr_q;
    assign instruction_valid   = ~fifo_empty_s & ~redirect_valid & ~rst;
    assign instruction         = head_s.instruction;
    assign instruction_address = head_s.address;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush_s),
        .push       (keep_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .empty      (fifo_empty_s),
        .head       (head_s)
    );

    // Next state for request issue, PC, reservations and stale-response accounting.
    always_comb begin
        pc_d        = pc_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        resp_addr_d = resp_addr_q;
        resv_d      = resv_q;
        stale_d     = stale_q;
        outst_d     = outst_q + (accept_s ? ONE_C : ZERO_C) - (mem_resp_valid ? ONE_C : ZERO_C);
        if (redirect_valid) begin
            // Everything still in flight becomes stale; the pending request stays on the bus.
            pc_d        = word_align(redirect_target);
            resp_addr_d = word_align(redirect_target);
            req_valid_d = req_valid_q & ~accept_s;
            stale_d     = outst_q + (req_valid_q ? ONE_C : ZERO_C)
                          - (mem_resp_valid ? ONE_C : ZERO_C);
            resv_d      = stale_d;
        end else begin
            if (load_s) begin
                req_valid_d = 1'b1;
                req_addr_d  = pc_q;
                pc_d        = pc_q + FETCH_STRIDE;
            end else if (accept_s) begin
                req_valid_d = 1'b0;
            end else begin
                req_valid_d = req_valid_q;
            end
            if (keep_s) begin
                resp_addr_d = resp_addr_q + FETCH_STRIDE;
            end else begin
                resp_addr_d = resp_addr_q;
            end
            if (drop_s) begin
                stale_d = stale_q - ONE_C;
            end else begin
                stale_d = stale_q;
            end
            resv_d = resv_q + (load_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C)
                     - (drop_s ? ONE_C : ZERO_C);
        end
    end

    // State registers with synchronous reset; redirects and responses are ignored in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_ADDRESS;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'h0000_0000;
            resp_addr_q <= RESET_ADDRESS;
            resv_q      <= ZERO_C;
            stale_q     <= ZERO_C;
            outst_q     <= ZERO_C;
        end else begin
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            resp_addr_q <= resp_addr_d;
            resv_q      <= resv_d;
            stale_q     <= stale_d;
            outst_q     <= outst_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: in-order memory model, queue-based
// reference model of the fetch unit, directed scenarios and a randomized phase.
module tb_instruction_fetch;

    localparam int          DEPTH = 4;
    localparam logic [0:31] RA    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [0:31] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [0:31] mem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [0:31] redirect_target = 32'h0;
    logic        instruction_valid;
    logic        instruction_ready = 1'b0;
    logic [0:31] instruction;
    logic [0:31] instruction_address;

    instruction_fetch #(.FIFO_DEPTH(DEPTH), .RESET_ADDRESS(RA)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_addr        (mem_req_addr),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_data       (mem_resp_data),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .instruction_valid   (instruction_valid),
        .instruction_ready   (instruction_ready),
        .instruction         (instruction),
        .instruction_address (instruction_address)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    typedef struct { logic [0:31] addr; bit stale; } req_t;
    typedef struct { logic [0:31] addr; logic [0:31] data; } ent_t;
    req_t        inflight[$];
    ent_t        m_buf[$];
    bit          m_pv;
    bit          m_ps;
    logic [0:31] m_pa;
    logic [0:31] m_pc;

    // Memory environment
    typedef struct { logic [0:31] addr; int due; } mreq_t;
    mreq_t memq[$];
    int    last_due = -1;
    int    lat_min  = 1;
    int    lat_max  = 1;

    // Observation logs
    logic [0:31] acc_log[$];
    logic [0:31] seen_addr[$];
    int          seen_cyc[$];

    function automatic logic [0:31] data_of(input logic [0:31] a);
        return {a[16:31], a[0:15]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [0:31] seen_at(input int i);
        if (i < seen_addr.size()) return seen_addr[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [0:31] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [0:31] act, input logic [0:31] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        seen_addr.delete();
        seen_cyc.delete();
    endtask

    // Advance the reference model across one rising edge.
    task automatic model_update(input bit r, input bit rdy, input bit drdy, input bit redir,
                                input logic [0:31] tgt, input bit rv);
        int   resv;
        bit   acc;
        bit   pop;
        req_t e;
        if (r) begin
            inflight.delete();
            m_buf.delete();
            m_pv = 1'b0;
            m_ps = 1'b0;
            m_pa = 32'h0;
            m_pc = RA;
            return;
        end
        resv = int'(m_pv) + inflight.size() + m_buf.size();
        acc  = m_pv && rdy;
        pop  = !redir && (m_buf.size() > 0) && drdy;
        if (redir) begin
            m_ps = 1'b1;
            foreach (inflight[i]) inflight[i].stale = 1'b1;
        end
        if (pop) void'(m_buf.pop_front());
        if (rv) begin
            check("resp_has_request", 32'(inflight.size() > 0), 32'h1);
            if (inflight.size() > 0) begin
                e = inflight.pop_front();
                if (!e.stale && !redir) m_buf.push_back('{e.addr, data_of(e.addr)});
            end
        end
        if (acc) inflight.push_back('{m_pa, m_ps});
        if (redir) begin
            m_buf.delete();
            m_pc = {tgt[0:29], 2'b00};
            if (acc) m_pv = 1'b0;
        end else if ((!m_pv || acc) && resv < DEPTH) begin
            m_pv = 1'b1;
            m_pa = m_pc;
            m_ps = 1'b0;
            m_pc = m_pc + 32'd4;
        end else if (acc) begin
            m_pv = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, update environment and model.
    task automatic step(input bit r, input bit rdy, input bit drdy, input bit redir,
                        input logic [0:31] tgt);
        bit          rv;
        logic [0:31] rd;
        mreq_t       m;
        bit          exp_iv;
        int          due;
        @(negedge clk);
        rv = 1'b0;
        rd = $urandom;
        if (!r && memq.size() > 0 && memq[0].due <= cyc) begin
            m  = memq.pop_front();
            rv = 1'b1;
            rd = data_of(m.addr);
        end else if (r) begin
            rv = 1'($urandom_range(0, 1));
        end
        rst               = r;
        mem_req_ready     = rdy;
        mem_resp_valid    = rv;
        mem_resp_data     = rd;
        redirect_valid    = redir;
        redirect_target   = tgt;
        instruction_ready = drdy;
        #1;
        exp_iv = !redir && (m_buf.size() > 0);
        if (!r) begin
            check("req_valid", 32'(mem_req_valid), 32'(m_pv));
            if (m_pv) check("req_addr", mem_req_addr, m_pa);
            check("instr_valid", 32'(instruction_valid), 32'(exp_iv));
            if (exp_iv) begin
                check("instr_addr", instruction_address, m_buf[0].addr);
                check("instr_data", instruction, m_buf[0].data);
            end
            if (instruction_valid && drdy) begin
                seen_addr.push_back(instruction_address);
                seen_cyc.push_back(cyc);
            end
            if (mem_req_valid && rdy) begin
                due = cyc + int'($urandom_range(lat_min, lat_max));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{mem_req_addr, due});
                acc_log.push_back(mem_req_addr);
            end
        end else begin
            memq.delete();
            last_due = -1;
        end
        model_update(r, rdy, drdy, redir, tgt, rv && !r);
        @(posedge clk);
        cyc++;
    endtask

    task automatic reset_dut();
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        logic [0:31] tgt;
        bit          r;
        bit          redir;

        // Reset release and streaming at one instruction per cycle
        lat_min = 1; lat_max = 1;
        reset_dut();
        #2;
        check("rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_instr_valid", 32'(instruction_valid), 32'h0);
        clear_logs();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        #2;
        check("first_req_valid", 32'(mem_req_valid), 32'h1);
        check("first_req_addr", mem_req_addr, 32'h0000_0100);
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("stream_0", seen_at(0), 32'h0000_0100);
        check("stream_1", seen_at(1), 32'h0000_0104);
        check("stream_2", seen_at(2), 32'h0000_0108);
        if (seen_cyc.size() >= 3) check("stream_rate", 32'(seen_cyc[2] - seen_cyc[0]), 32'd2);
        else check("stream_rate", 32'(seen_cyc.size()), 32'd3);

        // Decode stalled: reservations cap the number of requests
        reset_dut();
        clear_logs();
        repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("stall_req_count", 32'(acc_log.size()), 32'd4);
        #2;
        check("stall_req_idle", 32'(mem_req_valid), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        check("refill_req_valid", 32'(mem_req_valid), 32'h1);
        check("refill_req_addr", mem_req_addr, 32'h0000_0110);

        // Redirect with three requests in flight
        reset_dut();
        clear_logs();
        lat_min = 3; lat_max = 3;
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2003);
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_first", seen_at(0), 32'h0000_2000);
        check("redir_second", seen_at(1), 32'h0000_2004);

        // Redirect while a request is pending and unaccepted
        reset_dut();
        clear_logs();
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        check("hold_valid", 32'(mem_req_valid), 32'h1);
        check("hold_addr", mem_req_addr, 32'h0000_0100);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        #2;
        check("after_accept_addr", mem_req_addr, 32'h0000_2000);
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("pending_redir_first", seen_at(0), 32'h0000_2000);

        // PC wrap at the top of the address space
        reset_dut();
        clear_logs();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("wrap_req_top", acc_at(1), 32'hFFFF_FFFC);
        check("wrap_req_next", acc_at(2), 32'h0000_0000);
        check("wrap_instr", seen_at(2), 32'h0000_0000);

        // Reset with buffered entries and responses outstanding
        reset_dut();
        clear_logs();
        lat_min = 2; lat_max = 2;
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        check("midrst_req_valid", 32'(mem_req_valid), 32'h0);
        check("midrst_req_addr", mem_req_addr, 32'h0);
        check("midrst_instr_valid", 32'(instruction_valid), 32'h0);
        clear_logs();
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("restart_req", acc_at(0), 32'h0000_0100);
        check("restart_instr", seen_at(0), 32'h0000_0100);

        // Randomized traffic against the reference model
        reset_dut();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            r     = ($urandom_range(0, 199) == 0);
            redir = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
            else tgt = $urandom;
            step(r, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, redir, tgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
